// File: rtl/accum_alu.sv
// accum_alu: accumulator ALU with valid/ready handshake and optional saturation
module accum_alu #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic [7:0]       op_count
);
  localparam logic [1:0] SUB = 2'b01, ACC = 2'b10, CLR = 2'b11;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH:0]   wide;
  logic             accept;
  logic             carry;
  assign in_ready = rst_n & ena & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  // one extra bit of headroom: its top bit is the carry (ADD/ACC) or borrow (SUB)
  always_comb begin
    wide     = mode == SUB ? {1'b0, a} - {1'b0, b} :
               mode == ACC ? {1'b0, acc} + {1'b0, a} : {1'b0, a} + {1'b0, b};
    carry    = wide[WIDTH];
    res_next = carry && SATURATE ? (mode == SUB ? {WIDTH{1'b0}} : {WIDTH{1'b1}}) : wide[WIDTH-1:0];
  end
  // result register, flags, accumulator and beat counter; result is replaced without a bubble
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid  <= 1'b0;
      result     <= '0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
      op_count   <= '0;
      acc        <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      op_count   <= op_count + 8'd1;
      result     <= mode == CLR ? '0 : res_next;
      ovf        <= mode != CLR && carry;
      ovf_sticky <= mode != CLR && (ovf_sticky || carry);
      if (mode == CLR || mode == ACC) acc <= mode == CLR ? '0 : res_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_accum_alu.sv
// tb_accum_alu: scoreboard bench for accum_alu, saturating and wrapping instances side by side
module tb_accum_alu;
  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] a = 8'd0, b = 8'd0;
  logic       rdy_s, rdy_w, ov_s, ov_w, of_s, of_w, st_s, st_w;
  logic [7:0] res_s, res_w, cnt_s, cnt_w;

  accum_alu #(.WIDTH(8), .SATURATE(1'b1)) u_s (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(rdy_s),
    .mode(mode), .a(a), .b(b), .out_valid(ov_s), .out_ready(out_ready),
    .result(res_s), .ovf(of_s), .ovf_sticky(st_s), .op_count(cnt_s));
  accum_alu #(.WIDTH(8), .SATURATE(1'b0)) u_w (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(rdy_w),
    .mode(mode), .a(a), .b(b), .out_valid(ov_w), .out_ready(out_ready),
    .result(res_w), .ovf(of_w), .ovf_sticky(st_w), .op_count(cnt_w));

  always #5 clk = ~clk;

  typedef struct {int rs; int os; int ss; int rw; int ow; int sw; int cnt;} exp_t;
  exp_t q[$];
  int  checks = 0, errors = 0;
  int  m_acc_s = 0, m_acc_w = 0, m_st_s = 0, m_st_w = 0, m_cnt = 0;
  bit  m_ov = 0, last_acc = 0;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, act, exp);
    end
  endtask

  // unsigned 8-bit arithmetic from plain integers; sat selects clamp vs modulo-256
  function automatic void arith(input bit sub, input int x, input int y, input bit sat,
                                output int r, output int o);
    int v = sub ? x - y : x + y;
    o = (v < 0 || v > 255) ? 1 : 0;
    r = !o ? v : sat ? (sub ? 0 : 255) : (v + 256) % 256;
  endfunction

  // reference model: decide acceptance and push the expected beat
  always @(posedge clk) if (rst_n) begin
    exp_t e;
    int r, o;
    last_acc = in_valid && ena && (!m_ov || out_ready);
    if (last_acc) begin
      m_cnt = (m_cnt + 1) % 256;
      if (mode == 2'd3) begin
        m_acc_s = 0; m_acc_w = 0; m_st_s = 0; m_st_w = 0;
        e = '{0, 0, 0, 0, 0, 0, m_cnt};
      end else begin
        e.cnt = m_cnt;
        if (mode == 2'd2) begin
          arith(0, m_acc_s, int'(a), 1, r, o); m_acc_s = r; e.rs = r; e.os = o;
          arith(0, m_acc_w, int'(a), 0, r, o); m_acc_w = r; e.rw = r; e.ow = o;
        end else begin
          arith(mode == 2'd1, int'(a), int'(b), 1, r, o); e.rs = r; e.os = o;
          arith(mode == 2'd1, int'(a), int'(b), 0, r, o); e.rw = r; e.ow = o;
        end
        m_st_s = m_st_s | e.os; m_st_w = m_st_w | e.ow;
        e.ss = m_st_s; e.sw = m_st_w;
      end
      q.push_back(e);
    end
    m_ov = last_acc ? 1'b1 : out_ready ? 1'b0 : m_ov;
  end

  // monitor: handshake checks every cycle, pop and compare on each consumed result
  always @(negedge clk) if (rst_n) begin
    exp_t e;
    chk("in_ready_s", rdy_s, ena && (!m_ov || out_ready));
    chk("in_ready_w", rdy_w, ena && (!m_ov || out_ready));
    chk("out_valid_s", ov_s, m_ov);
    chk("out_valid_w", ov_w, m_ov);
    if (ov_s && out_ready) begin
      if (q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        e = q.pop_front();
        chk("result_s", res_s, e.rs); chk("ovf_s", of_s, e.os); chk("sticky_s", st_s, e.ss);
        chk("result_w", res_w, e.rw); chk("ovf_w", of_w, e.ow); chk("sticky_w", st_w, e.sw);
        chk("op_count_s", cnt_s, e.cnt); chk("op_count_w", cnt_w, e.cnt);
      end
    end
  end

  task automatic cyc(input bit e, input bit v, input int m, input int x, input int y, input bit r);
    ena = e; in_valid = v; mode = 2'(m); a = 8'(x); b = 8'(y); out_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string n);
    chk({n, "_out_valid"}, ov_s | ov_w, 0);
    chk({n, "_result"}, res_s | res_w, 0);
    chk({n, "_ovf"}, of_s | of_w | st_s | st_w, 0);
    chk({n, "_op_count"}, cnt_s | cnt_w, 0);
    chk({n, "_in_ready"}, rdy_s | rdy_w, 0);
  endtask

  // drop rst_n between clock edges, check outputs immediately, then release off-edge
  task automatic async_reset(input string n);
    in_valid = 1'b0; ena = 1'b0;
    #2 rst_n = 1'b0;
    q.delete(); m_acc_s = 0; m_acc_w = 0; m_st_s = 0; m_st_w = 0; m_cnt = 0; m_ov = 0;
    #1 check_reset_outputs(n);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2 check_reset_outputs("por");
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    // saturating and wrapping add with carry
    cyc(1, 1, 0, 200, 100, 1);
    chk("add_sat_result", res_s, 255); chk("add_sat_ovf", of_s, 1); chk("add_sat_sticky", st_s, 1);
    chk("add_wrap_result", res_w, 44);
    // wrapping subtract with borrow, then sticky survives a clean add
    cyc(1, 1, 1, 5, 7, 1);
    chk("sub_wrap_result", res_w, 254); chk("sub_wrap_ovf", of_w, 1); chk("sub_sat_result", res_s, 0);
    cyc(1, 1, 0, 3, 4, 1);
    chk("add_after_result", res_w, 7); chk("add_after_ovf", of_w, 0); chk("add_after_sticky", st_w, 1);
    // accumulate to saturation then clear from a fresh reset
    async_reset("rst1");
    cyc(1, 1, 2, 100, 0, 1); chk("acc1", res_s, 100);
    cyc(1, 1, 2, 100, 0, 1); chk("acc2", res_s, 200);
    cyc(1, 1, 2, 100, 0, 1); chk("acc3", res_s, 255); chk("acc3_ovf", of_s, 1);
    cyc(1, 1, 3, 0, 0, 1);
    chk("clr_result", res_s, 0); chk("clr_sticky", st_s, 0); chk("clr_count", cnt_s, 4);
    // back-pressure holds the result, then replacement without a bubble
    cyc(1, 1, 0, 1, 2, 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("bp_held", res_s, 3); chk("bp_in_ready", rdy_s, 0);
    cyc(1, 1, 0, 4, 4, 1);
    chk("bp_replace", res_s, 8); chk("bp_valid", ov_s, 1);
    // disabled block refuses beats but still drains
    cyc(0, 1, 0, 9, 9, 1);
    cyc(0, 1, 0, 9, 9, 1);
    chk("ena_count", cnt_s, 6); chk("ena_drained", ov_s, 0);
    // reset in the middle of an accumulation
    cyc(1, 1, 2, 5, 0, 0);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 1, 2, 6, 0, 0);
    async_reset("rst2");
    cyc(1, 1, 2, 10, 0, 1); chk("acc_fresh", res_s, 10);
    // randomized traffic; an offered beat is held until accepted
    for (int i = 0; i < 600; i++) begin
      if (in_valid && !last_acc)
        cyc(($urandom % 4) != 0, 1, mode, a, b, $urandom % 3 != 0);
      else
        cyc(($urandom % 4) != 0, $urandom % 2, $urandom % 4, $urandom % 256, $urandom % 256,
            $urandom % 3 != 0);
    end
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
